// File: rtl/ss_find_min.sv
// Selection-sort scan stage: tracks the smallest (or, with SS_FIND_MAX_EN, the
// largest) element of a streamed RAM window and its address, then pulses done.
module ss_find_min #(
  parameter int SIZE_ADDR = 6,
  parameter int SIZE_DATA = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start_find,
  input  logic [SIZE_ADDR-1:0] i_si_ram,
  input  logic [SIZE_DATA-1:0] i_data_ram,
  input  logic                 i_data_valid,
  input  logic                 i_done_read_data,
  output logic [SIZE_DATA-1:0] o_min_data,
  output logic [SIZE_ADDR-1:0] o_min_addr,
  output logic                 o_found,
  output logic                 o_busy,
  output logic                 o_done_find
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state;
  logic [SIZE_ADDR-1:0] cur_addr;
  logic                 better;

  // Strict comparison so ties keep the earliest element in either mode.
  always_comb begin
    better = 1'b0;
`ifdef SS_FIND_MAX_EN
    better = (i_data_ram > o_min_data);
`else
    better = (i_data_ram < o_min_data);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cur_addr    <= '0;
      o_min_data  <= '0;
      o_min_addr  <= '0;
      o_found     <= 1'b0;
      o_busy      <= 1'b0;
      o_done_find <= 1'b0;
    end else if (i_start_find) begin
      // A start wins over any stream activity in the same cycle.
      state       <= SCAN;
      cur_addr    <= i_si_ram;
      o_min_data  <= '0;
      o_min_addr  <= '0;
      o_found     <= 1'b0;
      o_busy      <= 1'b1;
      o_done_find <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_busy      <= 1'b0;
          o_done_find <= 1'b0;
        end
        SCAN: begin
          if (i_data_valid) begin
            if (!o_found || better) begin
              o_min_data <= i_data_ram;
              o_min_addr <= cur_addr;
              o_found    <= 1'b1;
            end
            cur_addr <= cur_addr + 1'b1;
          end
          if (i_done_read_data) begin
            state       <= DONE;
            o_busy      <= 1'b0;
            o_done_find <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          o_busy      <= 1'b0;
          o_done_find <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          o_busy      <= 1'b0;
          o_done_find <= 1'b0;
        end
      endcase
    end
  end

endmodule
